mem_port_arbiter: RTL and testbench

Shares the single 32-bit memory port between the instruction fetcher and the load/store unit. Each side issues requests on a valid/ready handshake identical to the fetcher's memory interface. The arbiter picks one requester, drives the memory port from registered copies of that request, and routes the one-cycle response back. It sits between the core's fetch/LSU stages and the memory controller, and adds a watchdog that aborts transactions the memory never acknowledges.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_rr_arbiter2.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the core's memory port arbitration.
// mem_grant_t names the current owner of the port and doubles as the arbiter FSM state.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_MASK_W = 4;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } mem_grant_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between fetch and load/store requests.
// Holds the last winner; on a tie the other side is chosen.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_inst_i,
    input  logic       req_data_i,
    input  logic       update_i,
    output mem_grant_t pick_o
);

    mem_grant_t last_grant_q;
    mem_grant_t last_grant_d;

    always_comb begin
        pick_o = GRANT_NONE;
        if (req_inst_i && req_data_i) begin
            if (last_grant_q == GRANT_DATA) begin
                pick_o = GRANT_INST;
            end else begin
                pick_o = GRANT_DATA;
            end
        end else if (req_inst_i) begin
            pick_o = GRANT_INST;
        end else if (req_data_i) begin
            pick_o = GRANT_DATA;
        end

        last_grant_d = last_grant_q;
        if (update_i && (pick_o != GRANT_NONE)) begin
            last_grant_d = pick_o;
        end
    end

    // Starting from DATA lets the fetcher win the very first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU with round-robin grants,
// registered request signals, a pass-through response and a no-ack watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MEM_ADDR_W-1:0] inst_in_addr,
    input  logic                  inst_in_valid,
    output logic [MEM_DATA_W-1:0] inst_in_data,
    output logic                  inst_in_ready,
    input  logic [MEM_ADDR_W-1:0] data_in_addr,
    input  logic                  data_in_valid,
    input  logic                  data_in_write,
    input  logic [MEM_DATA_W-1:0] data_in_wdata,
    input  logic [MEM_MASK_W-1:0] data_in_wmask,
    output logic [MEM_DATA_W-1:0] data_in_rdata,
    output logic                  data_in_ready,
    output logic [MEM_ADDR_W-1:0] mem_out_addr,
    output logic                  mem_out_write,
    output logic [MEM_DATA_W-1:0] mem_out_wdata,
    output logic [MEM_MASK_W-1:0] mem_out_wmask,
    output logic                  mem_out_valid,
    input  logic [MEM_DATA_W-1:0] mem_out_data,
    input  logic                  mem_out_ready,
    output logic                  timeout_error
);

    localparam int unsigned     CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit              WDOG_EN     = (TIMEOUT_CYCLES != 0);

    mem_grant_t            state_q, state_d;
    mem_grant_t            pick;
    logic                  grantEn;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
    logic [MEM_MASK_W-1:0] wmask_q, wmask_d;
    logic                  timeout_q, timeout_d;
    logic                  done;
    logic [MEM_DATA_W-1:0] respData;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .req_inst_i (inst_in_valid),
        .req_data_i (data_in_valid),
        .update_i   (grantEn),
        .pick_o     (pick)
    );

    // Completion is decided combinationally so ready lands in the same cycle as mem_out_ready.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        addr_d        = addr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        timeout_d     = timeout_q;
        grantEn       = 1'b0;
        done          = 1'b0;
        respData      = '0;
        inst_in_ready = 1'b0;
        inst_in_data  = '0;
        data_in_ready = 1'b0;
        data_in_rdata = '0;

        case (state_q)
            GRANT_NONE: begin
                if (pick != GRANT_NONE) begin
                    grantEn    = 1'b1;
                    state_d    = pick;
                    wait_cnt_d = '0;
                    if (pick == GRANT_INST) begin
                        addr_d  = inst_in_addr;
                        write_d = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end else begin
                        addr_d  = data_in_addr;
                        write_d = data_in_write;
                        wdata_d = data_in_wdata;
                        wmask_d = data_in_wmask;
                    end
                end
            end
            GRANT_INST, GRANT_DATA: begin
                if (mem_out_ready) begin
                    done     = 1'b1;
                    respData = mem_out_data;
                end else if (WDOG_EN && (wait_cnt_q == TIMEOUT_CNT)) begin
                    done      = 1'b1;
                    timeout_d = 1'b1;
                end else if (WDOG_EN) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end

                if (done) begin
                    state_d = GRANT_NONE;
                end

                if (state_q == GRANT_INST) begin
                    inst_in_ready = done;
                    inst_in_data  = respData;
                end else begin
                    data_in_ready = done;
                    data_in_rdata = respData;
                end
            end
            default: begin
                state_d = GRANT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= GRANT_NONE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_out_valid = (state_q != GRANT_NONE);
    assign mem_out_addr  = addr_q;
    assign mem_out_write = write_q;
    assign mem_out_wdata = wdata_q;
    assign mem_out_wmask = wmask_q;
    assign timeout_error = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset/fetch/async-reset cases, then random
// traffic checked against a transaction-level model of grants, responses and aborts.
module tb_mem_port_arbiter;

    localparam int TIMEOUT       = 8;
    localparam int RANDOM_CYCLES = 4000;
    localparam int NEVER         = 1000;

    typedef struct packed {
        logic        pending;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    logic        clk;
    logic        reset;
    logic [31:0] inst_in_addr;
    logic        inst_in_valid;
    logic [31:0] inst_in_data;
    logic        inst_in_ready;
    logic [31:0] data_in_addr;
    logic        data_in_valid;
    logic        data_in_write;
    logic [31:0] data_in_wdata;
    logic [3:0]  data_in_wmask;
    logic [31:0] data_in_rdata;
    logic        data_in_ready;
    logic [31:0] mem_out_addr;
    logic        mem_out_write;
    logic [31:0] mem_out_wdata;
    logic [3:0]  mem_out_wmask;
    logic        mem_out_valid;
    logic [31:0] mem_out_data;
    logic        mem_out_ready;
    logic        timeout_error;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_in_addr  (inst_in_addr),
        .inst_in_valid (inst_in_valid),
        .inst_in_data  (inst_in_data),
        .inst_in_ready (inst_in_ready),
        .data_in_addr  (data_in_addr),
        .data_in_valid (data_in_valid),
        .data_in_write (data_in_write),
        .data_in_wdata (data_in_wdata),
        .data_in_wmask (data_in_wmask),
        .data_in_rdata (data_in_rdata),
        .data_in_ready (data_in_ready),
        .mem_out_addr  (mem_out_addr),
        .mem_out_write (mem_out_write),
        .mem_out_wdata (mem_out_wdata),
        .mem_out_wmask (mem_out_wmask),
        .mem_out_valid (mem_out_valid),
        .mem_out_data  (mem_out_data),
        .mem_out_ready (mem_out_ready),
        .timeout_error (timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    req_t        reqI, reqD, granted;
    bit          busy, idleForced, stickyErr, done, aborted;
    bit          expIR, expDR;
    int          owner, lastWinner, age, latency;
    logic [31:0] memData;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        inst_in_valid = reqI.pending;
        inst_in_addr  = reqI.addr;
        data_in_valid = reqD.pending;
        data_in_addr  = reqD.addr;
        data_in_write = reqD.write;
        data_in_wdata = reqD.wdata;
        data_in_wmask = reqD.wmask;
    endtask

    function automatic req_t newReq(input bit isFetch);
        req_t r;
        r.pending = 1'b1;
        r.addr    = $urandom;
        r.write   = isFetch ? 1'b0 : 1'($urandom_range(0, 1));
        r.wdata   = $urandom;
        r.wmask   = 4'($urandom_range(0, 15));
        return r;
    endfunction

    initial begin
        reset         = 1'b1;
        reqI          = '0;
        reqD          = '0;
        mem_out_ready = 1'b0;
        mem_out_data  = '0;
        applyStimulus();
        repeat (3) @(negedge clk);

        checkOutput("rst_valid", 32'(mem_out_valid), 32'd0);
        checkOutput("rst_addr", mem_out_addr, 32'd0);
        checkOutput("rst_write", 32'(mem_out_write), 32'd0);
        checkOutput("rst_wdata", mem_out_wdata, 32'd0);
        checkOutput("rst_wmask", 32'(mem_out_wmask), 32'd0);
        checkOutput("rst_iready", 32'(inst_in_ready), 32'd0);
        checkOutput("rst_dready", 32'(data_in_ready), 32'd0);
        checkOutput("rst_idata", inst_in_data, 32'd0);
        checkOutput("rst_ddata", data_in_rdata, 32'd0);
        checkOutput("rst_timeout", 32'(timeout_error), 32'd0);
        reset = 1'b0;

        // Single fetch answered three cycles after the grant.
        reqI.pending = 1'b1;
        reqI.addr    = 32'h100;
        applyStimulus();
        @(negedge clk);
        checkOutput("fetch_valid", 32'(mem_out_valid), 32'd1);
        checkOutput("fetch_addr", mem_out_addr, 32'h100);
        checkOutput("fetch_write", 32'(mem_out_write), 32'd0);
        checkOutput("fetch_wmask", 32'(mem_out_wmask), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("fetch_wait_ready", 32'(inst_in_ready), 32'd0);
            @(negedge clk);
        end
        mem_out_ready = 1'b1;
        mem_out_data  = 32'h13;
        #1;
        checkOutput("fetch_ready", 32'(inst_in_ready), 32'd1);
        checkOutput("fetch_data", inst_in_data, 32'h13);
        checkOutput("fetch_other_ready", 32'(data_in_ready), 32'd0);
        reqI.pending = 1'b0;
        applyStimulus();
        @(negedge clk);
        mem_out_ready = 1'b0;
        #1;
        checkOutput("fetch_pulse_end", 32'(inst_in_ready), 32'd0);
        checkOutput("fetch_idle_gap", 32'(mem_out_valid), 32'd0);

        // Reset asserted between edges while a load holds the port.
        reqD.pending = 1'b1;
        reqD.addr    = 32'h8000;
        reqD.write   = 1'b0;
        applyStimulus();
        @(negedge clk);
        @(negedge clk);
        checkOutput("load_valid", 32'(mem_out_valid), 32'd1);
        checkOutput("load_addr", mem_out_addr, 32'h8000);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(mem_out_valid), 32'd0);
        checkOutput("arst_addr", mem_out_addr, 32'd0);
        mem_out_ready = 1'b1;
        mem_out_data  = 32'hDEADBEEF;
        #1;
        checkOutput("arst_dready", 32'(data_in_ready), 32'd0);
        checkOutput("arst_iready", 32'(inst_in_ready), 32'd0);
        reqD = '0;
        applyStimulus();
        mem_out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Random traffic starting with a tie: fetch 0x200 vs load 0x8000.
        reqI         = newReq(1'b1);
        reqI.addr    = 32'h200;
        reqD         = newReq(1'b0);
        reqD.addr    = 32'h8000;
        reqD.write   = 1'b0;
        applyStimulus();
        busy       = 1'b0;
        idleForced = 1'b0;
        stickyErr  = 1'b0;
        lastWinner = 1;
        owner      = 0;
        age        = 0;
        latency    = 0;
        granted    = '0;

        for (int cyc = 0; cyc < RANDOM_CYCLES; cyc++) begin
            @(negedge clk);
            if (!busy && !idleForced && (reqI.pending || reqD.pending)) begin
                busy = 1'b1;
                age  = 0;
                if (reqI.pending && reqD.pending) begin
                    owner = (lastWinner == 1) ? 0 : 1;
                end else begin
                    owner = reqI.pending ? 0 : 1;
                end
                lastWinner = owner;
                if (owner == 0) begin
                    granted       = reqI;
                    granted.write = 1'b0;
                    granted.wmask = '0;
                end else begin
                    granted = reqD;
                end
                latency = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 6);
            end
            idleForced = 1'b0;

            memData      = $urandom;
            mem_out_data = memData;
            if (busy) begin
                mem_out_ready = (age == latency);
            end else begin
                mem_out_ready = ($urandom_range(0, 3) == 0);
            end
            #1;

            done    = busy && ((age == latency) || (age == TIMEOUT));
            aborted = busy && (age == TIMEOUT) && (age != latency);
            expIR   = done && (owner == 0);
            expDR   = done && (owner == 1);

            checkOutput("valid", 32'(mem_out_valid), 32'(busy));
            if (busy) begin
                checkOutput("req_addr", mem_out_addr, granted.addr);
                checkOutput("req_write", 32'(mem_out_write), 32'(granted.write));
                checkOutput("req_wmask", 32'(mem_out_wmask), 32'(granted.wmask));
                if (owner == 1) begin
                    checkOutput("req_wdata", mem_out_wdata, granted.wdata);
                end
            end
            checkOutput("inst_ready", 32'(inst_in_ready), 32'(expIR));
            checkOutput("data_ready", 32'(data_in_ready), 32'(expDR));
            if (expIR) begin
                checkOutput("inst_data", inst_in_data, aborted ? 32'd0 : memData);
            end else if (!(busy && owner == 0)) begin
                checkOutput("inst_data_idle", inst_in_data, 32'd0);
            end
            if (expDR) begin
                checkOutput("data_rdata", data_in_rdata, aborted ? 32'd0 : memData);
            end else if (!(busy && owner == 1)) begin
                checkOutput("data_rdata_idle", data_in_rdata, 32'd0);
            end
            checkOutput("timeout_err", 32'(timeout_error), 32'(stickyErr));
            if (aborted) begin
                stickyErr = 1'b1;
            end

            if (done) begin
                busy       = 1'b0;
                idleForced = 1'b1;
                if (owner == 0) begin
                    reqI = $urandom_range(0, 1) ? newReq(1'b1) : '0;
                end else begin
                    reqD = $urandom_range(0, 1) ? newReq(1'b0) : '0;
                end
            end else if (busy) begin
                age++;
            end
            if (!reqI.pending && ($urandom_range(0, 3) == 0)) begin
                reqI = newReq(1'b1);
            end
            if (!reqD.pending && ($urandom_range(0, 3) == 0)) begin
                reqD = newReq(1'b0);
            end
            applyStimulus();
            if (busy && !done) begin
                if (owner == 0) begin
                    inst_in_addr = $urandom;
                end else begin
                    data_in_addr  = $urandom;
                    data_in_wdata = $urandom;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
